// File: rtl/alu_fu_buffered.sv
// Integer ALU functional unit with a small result FIFO in front of the CDB.
// Each accepted issue is computed in the same cycle and queued until the arbiter grants it.
module alu_fu_buffered #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int ROB_W = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [TAG_W-1:0] issue_rd,
    input  logic [ROB_W-1:0] issue_rob_num,
    input  logic [XLEN-1:0]  issue_src1,
    input  logic [XLEN-1:0]  issue_src2,
    input  logic [XLEN-1:0]  issue_imm,
    input  logic [3:0]       issue_op,
    input  logic             issue_src_sel,
    input  logic             issue_reg_write,
    output logic             cdb_request,
    input  logic             cdb_grant,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [ROB_W-1:0] cdb_rob_num,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_reg_write
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SH_W-1:0]        sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[SH_W-1:0];
        case (op)
            4'd0:    alu_calc = a + b;
            4'd1:    alu_calc = a ^ b;
            4'd2:    alu_calc = a | b;
            4'd3:    alu_calc = $unsigned(sa >>> sh);
            4'd4:    alu_calc = b;
            4'd5:    alu_calc = a - b;
            4'd6:    alu_calc = a & b;
            4'd7:    alu_calc = a << sh;
            4'd8:    alu_calc = a >> sh;
            4'd9:    alu_calc = {{(XLEN-1){1'b0}}, (sa < sb)};
            4'd10:   alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
            default: alu_calc = '0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [ROB_W-1:0] rob_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic             rw_q   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic            empty;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] result;

    assign empty       = rst || (count == '0);
    assign issue_ready = !rst && (count < CNT_W'(DEPTH));
    assign push        = issue_valid && issue_ready && !flush;
    assign pop         = cdb_request && cdb_grant && !flush;
    assign result      = alu_calc(issue_op, issue_src1,
                                  issue_src_sel ? issue_imm : issue_src2);

    // Issue stage: result lands at the tail on the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                rob_q[i]  <= '0;
                data_q[i] <= '0;
                rw_q[i]   <= 1'b0;
            end
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                tag_q[tail]  <= issue_rd;
                rob_q[tail]  <= issue_rob_num;
                data_q[tail] <= result;
                rw_q[tail]   <= issue_reg_write;
                tail         <= ptr_next(tail);
            end
            if (pop)
                head <= ptr_next(head);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Broadcast stage: head entry drives the CDB, zeroed whenever nothing is queued
    assign cdb_request   = !empty;
    assign cdb_tag       = empty ? '0 : tag_q[head];
    assign cdb_rob_num   = empty ? '0 : rob_q[head];
    assign cdb_data      = empty ? '0 : data_q[head];
    assign cdb_reg_write = empty ? 1'b0 : rw_q[head];

endmodule
